// File: rtl/ir_nec_rx.sv
// NEC infrared remote receiver: measures mark/space widths in microsecond ticks
// and decodes 32-bit frames and repeat codes, with optional inverse-byte checking.
module ir_nec_rx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned LEAD_H_MIN = 8000,
    parameter int unsigned LEAD_L_MIN = 4000,
    parameter int unsigned RPT_L_MIN  = 2000,
    parameter int unsigned BIT1_L_MIN = 1000,
    parameter int unsigned TIMEOUT_US = 20000,
    parameter int unsigned CHECK_INV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rxb,
    output logic [31:0] o_data,
    output logic [7:0]  o_addr,
    output logic [7:0]  o_cmd,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned DIV = CLK_HZ / 1000000;
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [15:0] LEAD_H_TH = 16'(LEAD_H_MIN);
    localparam logic [15:0] LEAD_L_TH = 16'(LEAD_L_MIN);
    localparam logic [15:0] RPT_L_TH  = 16'(RPT_L_MIN);
    localparam logic [15:0] BIT1_TH   = 16'(BIT1_L_MIN);
    localparam logic [15:0] TMO_TH    = 16'(TIMEOUT_US);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLeadH = 3'd1;
    localparam logic [2:0] StLeadL = 3'd2;
    localparam logic [2:0] StDataH = 3'd3;
    localparam logic [2:0] StDataL = 3'd4;
    localparam logic [2:0] StCheck = 3'd5;

    logic [DW-1:0] div_q;
    logic          tick;
    logic [2:0]    sync_q;
    logic          rise, fall, edge_det;
    logic [15:0]   cnt_q, cnt_d;
    logic          tmo;

    logic [2:0]  state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        have_q, have_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        repeat_q, repeat_d;
    logic        err_q, err_d;
    logic        tmo_go;
    logic        bit_val;
    logic        inv_bad;

    // Free-running microsecond enable.
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // sync_q[0], sync_q[1] synchronize; sync_q[2] is the previous value for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1], sync_q[0], ~i_ir_rxb};
        end
    end

    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];
    assign edge_det = rise | fall;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_det) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo     = (cnt_q >= TMO_TH);
    assign bit_val = (cnt_q >= BIT1_TH);
    assign inv_bad = (shreg_q[15:8] != ~shreg_q[7:0]) || (shreg_q[31:24] != ~shreg_q[23:16]);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        have_d   = have_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        repeat_d = 1'b0;
        err_d    = 1'b0;
        tmo_go   = 1'b0;

        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d  = StLeadH;
                    bitcnt_d = '0;
                end
            end
            StLeadH: begin
                if (fall) begin
                    // Short marks are treated as noise and dropped silently.
                    state_d = (cnt_q >= LEAD_H_TH) ? StLeadL : StIdle;
                end else if (tmo) begin
                    tmo_go = 1'b1;
                end
            end
            StLeadL: begin
                if (rise) begin
                    if (cnt_q >= LEAD_L_TH) begin
                        state_d = StDataH;
                    end else begin
                        state_d  = StIdle;
                        repeat_d = (cnt_q >= RPT_L_TH) && have_q;
                    end
                end else if (tmo) begin
                    tmo_go = 1'b1;
                end
            end
            StDataH: begin
                if (fall) begin
                    state_d = StDataL;
                end else if (tmo) begin
                    tmo_go = 1'b1;
                end
            end
            StDataL: begin
                if (rise) begin
                    shreg_d  = {bit_val, shreg_q[31:1]};
                    bitcnt_d = bitcnt_q + 6'd1;
                    state_d  = (bitcnt_q == 6'd31) ? StCheck : StDataH;
                end else if (tmo) begin
                    tmo_go = 1'b1;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if ((CHECK_INV != 0) && inv_bad) begin
                    err_d  = 1'b1;
                    have_d = 1'b0;
                end else begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    have_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_go) begin
            state_d = StIdle;
            err_d   = 1'b1;
            have_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            have_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            have_q   <= have_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            repeat_q <= repeat_d;
            err_q    <= err_d;
        end
    end

    assign o_data   = data_q;
    assign o_addr   = data_q[7:0];
    assign o_cmd    = data_q[23:16];
    assign o_valid  = valid_q;
    assign o_repeat = repeat_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_ir_nec_rx.sv
// Randomized NEC bench: two receivers (inverse check on/off) on one line, checked
// against a frame-level event model with timing windows.
`timescale 1ns/1ps
module tb_ir_nec_rx;

    localparam int CLK_HZ    = 2000000;
    localparam int DIV       = 2;
    localparam int LEAD_H_TH = 80;
    localparam int LEAD_L_TH = 40;
    localparam int RPT_TH    = 20;
    localparam int BIT1_TH   = 10;
    localparam int TMO       = 200;

    typedef struct {
        int          kind;  // 1 valid, 2 repeat, 3 err
        logic [31:0] data;
        longint      lo;
        longint      hi;
        bit          tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_rxb = 1'b1;
    logic [31:0] data [2];
    logic [7:0]  addr [2];
    logic [7:0]  cmd [2];
    logic        valid [2];
    logic        rpt [2];
    logic        err [2];
    logic        busy [2];

    longint      cyc = 0;
    longint      last_edge = 0;
    int          checks = 0;
    int          errors = 0;
    bit          run = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          have [2];
    logic [31:0] cur [2];
    bit          prev_busy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 checks inverse bytes, instance 1 does not.
    ir_nec_rx #(.CLK_HZ(CLK_HZ), .LEAD_H_MIN(LEAD_H_TH), .LEAD_L_MIN(LEAD_L_TH),
                .RPT_L_MIN(RPT_TH), .BIT1_L_MIN(BIT1_TH), .TIMEOUT_US(TMO),
                .CHECK_INV(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir_rxb), .o_data(data[0]), .o_addr(addr[0]),
        .o_cmd(cmd[0]), .o_valid(valid[0]), .o_repeat(rpt[0]), .o_err(err[0]),
        .o_busy(busy[0]));

    ir_nec_rx #(.CLK_HZ(CLK_HZ), .LEAD_H_MIN(LEAD_H_TH), .LEAD_L_MIN(LEAD_L_TH),
                .RPT_L_MIN(RPT_TH), .BIT1_L_MIN(BIT1_TH), .TIMEOUT_US(TMO),
                .CHECK_INV(0)) dut_noinv (
        .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir_rxb), .o_data(data[1]), .o_addr(addr[1]),
        .o_cmd(cmd[1]), .o_valid(valid[1]), .o_repeat(rpt[1]), .o_err(err[1]),
        .o_busy(busy[1]));

    function automatic logic [31:0] nec(logic [7:0] a, logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    function automatic bit inv_ok(logic [31:0] w);
        return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
    endfunction

    function automatic bit q_empty(int k);
        return (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
    endfunction

    function automatic exp_t q_front(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(int k);
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic q_push(int k, int kind, logic [31:0] d, longint lo, longint hi, bit t);
        exp_t e;
        e.kind = kind; e.data = d; e.lo = lo; e.hi = hi; e.tmo = t;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Frame-level model: a complete 32-bit frame ends with the rise that starts the stop mark.
    task automatic model_frame(logic [31:0] w, longint n);
        for (int k = 0; k < 2; k++) begin
            if (k == 0 && !inv_ok(w)) begin
                q_push(k, 3, 32'h0, n + 2, n + 6, 1'b0);
                have[k] = 1'b0;
            end else begin
                q_push(k, 1, w, n + 2, n + 6, 1'b0);
                have[k] = 1'b1;
            end
        end
    endtask

    task automatic model_repeat(longint n);
        for (int k = 0; k < 2; k++)
            if (have[k]) q_push(k, 2, 32'h0, n + 1, n + 5, 1'b0);
    endtask

    task automatic model_timeout(longint n);
        for (int k = 0; k < 2; k++) begin
            q_push(k, 3, 32'h0, n + TMO * DIV - 2, n + TMO * DIV + DIV + 8, 1'b1);
            have[k] = 1'b0;
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && run) begin
            for (int k = 0; k < 2; k++) begin
                int   np;
                int   kind;
                exp_t e;
                np = int'(valid[k]) + int'(rpt[k]) + int'(err[k]);
                checks++;
                if (np > 1) begin
                    errors++;
                    $display("FAIL excl dut%0d v=%0b r=%0b e=%0b want at most one", k,
                             valid[k], rpt[k], err[k]);
                end
                if (np >= 1) begin
                    kind = valid[k] ? 1 : (rpt[k] ? 2 : 3);
                    checks++;
                    if (q_empty(k)) begin
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d kind %0d cyc %0d want none",
                                 k, kind, cyc);
                    end else begin
                        e = q_front(k);
                        q_pop(k);
                        if (kind != e.kind || cyc < e.lo || cyc > e.hi) begin
                            errors++;
                            $display("FAIL event dut%0d kind %0d cyc %0d want kind %0d in [%0d,%0d]",
                                     k, kind, cyc, e.kind, e.lo, e.hi);
                        end else if (kind == 1) begin
                            cur[k] = e.data;
                        end
                        if (e.tmo) begin
                            checks++;
                            if (!(prev_busy[k] && !busy[k])) begin
                                errors++;
                                $display("FAIL tmo_busy dut%0d prev %0b now %0b want 1 then 0",
                                         k, prev_busy[k], busy[k]);
                            end
                        end
                    end
                end else if (!q_empty(k)) begin
                    e = q_front(k);
                    if (e.hi < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing dut%0d kind %0d want by cyc %0d", k, e.kind, e.hi);
                        q_pop(k);
                    end
                end
                checks++;
                if (data[k] !== cur[k] || addr[k] !== cur[k][7:0] || cmd[k] !== cur[k][23:16]) begin
                    errors++;
                    $display("FAIL data dut%0d got %h/%h/%h want %h", k, data[k], addr[k], cmd[k],
                             cur[k]);
                end
                prev_busy[k] = busy[k];
            end
        end
    end

    task automatic drive(bit lvl);
        @(posedge clk);
        #1;
        ir_rxb    = ~lvl;
        last_edge = cyc;
    endtask

    task automatic hold(int us);
        repeat (us * DIV - 1) @(posedge clk);
    endtask

    task automatic seg(bit lvl, int us);
        drive(lvl);
        hold(us);
    endtask

    function automatic int rmark();
        return $urandom_range(3, 8);
    endfunction

    function automatic int rgap();
        return $urandom_range(30, 80);
    endfunction

    task automatic leader();
        seg(1'b1, $urandom_range(84, 110));
        seg(1'b0, $urandom_range(44, 60));
    endtask

    task automatic send_bits(logic [31:0] w, int nbits);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b1, rmark());
            seg(1'b0, w[i] ? $urandom_range(14, 20) : $urandom_range(3, 6));
        end
    endtask

    task automatic send_frame(logic [31:0] w);
        leader();
        send_bits(w, 32);
        drive(1'b1);
        model_frame(w, last_edge);
        hold(rmark());
        seg(1'b0, rgap());
    endtask

    task automatic send_repeat();
        seg(1'b1, $urandom_range(84, 110));
        seg(1'b0, $urandom_range(23, 36));
        drive(1'b1);
        model_repeat(last_edge);
        hold(rmark());
        seg(1'b0, rgap());
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            have[k] = 1'b0;
            cur[k] = 32'h0;
            prev_busy[k] = 1'b0;
        end
    endtask

    task automatic check_all_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_data"}, data[k], 32'h0);
            check({tag, "_pulses"}, {28'h0, valid[k], rpt[k], err[k], busy[k]}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] w;
        int          kind;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;
        seg(1'b0, 20);

        // Reference frame: addr 0x00, cmd 0x45.
        send_frame(nec(8'h00, 8'h45));
        @(negedge clk);
        check("ref_data", data[0], 32'hBA45FF00);
        check("ref_addr", {24'h0, addr[0]}, 32'h00);
        check("ref_cmd", {24'h0, cmd[0]}, 32'h45);
        check("ref_data_noinv", data[1], 32'hBA45FF00);

        send_repeat();
        @(negedge clk);
        check("rpt_data_held", data[0], 32'hBA45FF00);

        // Command inverse mismatch.
        send_frame(32'hBA46FF00);
        @(negedge clk);
        check("bad_data_held", data[0], 32'hBA45FF00);
        check("bad_data_noinv", data[1], 32'hBA46FF00);
        send_repeat();

        // Short mark is rejected; busy only while it lasts.
        drive(1'b1);
        hold(25);
        @(negedge clk);
        check("glitch_busy_mid", {31'h0, busy[0]}, 32'h1);
        hold(25);
        seg(1'b0, 40);
        @(negedge clk);
        check("glitch_busy_after", {31'h0, busy[0]}, 32'h0);

        // Truncated frame: 10 bits, then the line goes idle.
        leader();
        send_bits(32'h12345678, 10);
        seg(1'b1, 6);
        drive(1'b0);
        model_timeout(last_edge);
        hold(TMO + 20);
        @(negedge clk);
        check("tmo_busy_idle", {31'h0, busy[0]}, 32'h0);
        send_repeat();

        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: send_frame(nec(8'($urandom), 8'($urandom)));
                1: begin
                    w = $urandom;
                    send_frame(w);
                end
                2: send_repeat();
                default: begin
                    seg(1'b1, $urandom_range(30, 70));
                    seg(1'b0, rgap());
                end
            endcase
        end

        // Reset in the middle of a frame, then a clean frame.
        leader();
        send_bits(nec(8'h5A, 8'h11), 16);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        ir_rxb = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seg(1'b0, 40);
        send_frame(nec(8'h00, 8'h45));
        @(negedge clk);
        check("post_reset_data", data[0], 32'hBA45FF00);
        check("post_reset_cmd", {24'h0, cmd[0]}, 32'h45);

        hold(30);
        @(negedge clk);
        check("pending_events", 32'(q0.size() + q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency; CLK_HZ/1000000 SHALL be an integer >= 2.
REQ-002 Parameter LEAD_H_MIN, default 8000: minimum leader mark in us.
REQ-003 Parameter LEAD_L_MIN, default 4000: minimum leader space for a data frame in us.
REQ-004 Parameter RPT_L_MIN, default 2000: minimum leader space for a repeat code in us.
REQ-005 Parameter BIT1_L_MIN, default 1000: minimum data space in us that decodes as logic 1.
REQ-006 Parameter TIMEOUT_US, default 20000: maximum mark or space width in us inside a frame.
REQ-007 Parameter CHECK_INV, default 1: 1 enables the inverted address/command byte check, 0 disables it.
REQ-008 clk  input  1  system clock; the block has one clock.
REQ-009 rst_n  input  1  reset, asynchronous and active-low.
REQ-010 i_ir_rxb  input  1  raw IR receiver output, active-low (idle high); internal ir = ~i_ir_rxb, mark = ir high.
REQ-011 o_data  output  32  last accepted frame, first received bit at [0].
REQ-012 o_addr  output  8  o_data[7:0].
REQ-013 o_cmd  output  8  o_data[23:16].
REQ-014 o_valid  output  1  one-clk pulse when o_data updates.
REQ-015 o_repeat  output  1  one-clk pulse on a valid repeat code.
REQ-016 o_err  output  1  one-clk pulse on a timeout or check failure.
REQ-017 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Tick: a free-running divider SHALL emit a one-clk enable every CLK_HZ/1000000 clks (1 us); no derived clocks.
REQ-019 Input: ir SHALL pass a 2-flop synchronizer on clk; rise/fall edges are detected on the synchronized value, 1 clk after the second flop.
REQ-020 Width counter: 16-bit, SHALL clear on every detected edge, increment on each tick, and saturate at 65535.
REQ-021 FSM states: IDLE, LEAD_H, LEAD_L, DATA_H, DATA_L, CHECK.
REQ-022 IDLE: on rise -> LEAD_H; bit count := 0.
REQ-023 LEAD_H: on fall, cnt >= LEAD_H_MIN -> LEAD_L; otherwise -> IDLE with no pulse (glitch rejection).
REQ-024 LEAD_L: on rise, cnt >= LEAD_L_MIN -> DATA_H.
REQ-025 LEAD_L: on rise, RPT_L_MIN <= cnt < LEAD_L_MIN -> IDLE; o_repeat pulses only if the have_frame flag is set; o_data is unchanged.
REQ-026 LEAD_L: on rise, cnt < RPT_L_MIN -> IDLE with no pulse.
REQ-027 DATA_H: on fall -> DATA_L.
REQ-028 DATA_L: on rise, bit := (cnt >= BIT1_L_MIN) and shreg := {bit, shreg[31:1]}; bit count increments; at 32 bits -> CHECK, otherwise -> DATA_H.
REQ-029 Timeout: in LEAD_H, LEAD_L, DATA_H or DATA_L, cnt >= TIMEOUT_US without an edge -> IDLE, o_err pulse, have_frame := 0.
REQ-030 An edge and a timeout in the same clk: the edge SHALL take priority.
REQ-031 CHECK (one clk): if CHECK_INV=1 and (shreg[15:8] != ~shreg[7:0] or shreg[31:24] != ~shreg[23:16]), then o_err pulses, have_frame := 0 and o_data is held.
REQ-032 CHECK (one clk): otherwise o_data := shreg, o_valid pulses in the same clk as the update, and have_frame := 1.
REQ-033 CHECK always -> IDLE; edges arriving during CHECK SHALL be ignored.
REQ-034 o_valid, o_repeat and o_err SHALL be mutually exclusive and never high for more than 1 clk.
REQ-035 The trailing stop mark after bit 32 SHALL be consumed by IDLE->LEAD_H and then rejected by REQ-023 with no pulse.

Reset
REQ-036 rst_n low SHALL asynchronously set: state IDLE, all counters 0, shreg 0, synchronizer 0, have_frame 0.
REQ-037 rst_n low SHALL asynchronously set: o_data 0, o_valid/o_repeat/o_err/o_busy 0.
REQ-038 Reset mid-frame SHALL discard the partial frame; the first frame after release decodes normally.

Verification
REQ-039 NEC frame, addr 0x00, cmd 0x45 (9 ms/4.5 ms leader; 560 us marks; 560 us/1690 us spaces) -> o_data=0xBA45FF00, o_addr=0x00, o_cmd=0x45, single o_valid pulse.
REQ-040 After REQ-039: 9 ms mark, 2.25 ms space, 560 us mark -> one o_repeat pulse; o_data stays 0xBA45FF00.
REQ-041 Frame 0xBA46FF00 (command inverse mismatch), CHECK_INV=1 -> one o_err pulse, o_data unchanged, a following repeat code gives no o_repeat; with CHECK_INV=0 -> o_valid, o_data=0xBA46FF00.
REQ-042 Leader then 10 bits then line idle -> o_err exactly 20000 us (+-1 tick) after the last edge, o_busy falls with it.
REQ-043 5 ms mark glitch -> no pulses, o_busy high only during the glitch; rst_n asserted at bit 16 of a frame -> all outputs 0, the next full frame decodes per REQ-039.
